// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bus controller: takes one EXU memory request at a time, issues it to the
// bus arbiter with the proper strobes, and returns extended load data or an error.
module lsu_bus_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready_o,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] lsu_araddr_o,
    output logic              lsu_arvalid_o,
    output logic [7:0]        lsu_rstrb_o,
    input  logic [DATA_W-1:0] lsu_rdata,
    input  logic              lsu_rvalid,
    output logic [ADDR_W-1:0] lsu_awaddr_o,
    output logic              lsu_awvalid_o,
    output logic [DATA_W-1:0] lsu_wdata_o,
    output logic [7:0]        lsu_wstrb_o,
    output logic              lsu_wvalid_o,
    input  logic              lsu_wready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_d;
    logic [2:0]        funct3_p0;

    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic              rsp_err_d;
    logic [ADDR_W-1:0] araddr_d;
    logic              arvalid_d;
    logic [7:0]        rstrb_d;
    logic [ADDR_W-1:0] awaddr_d;
    logic              awvalid_d;
    logic [DATA_W-1:0] wdata_d;
    logic [7:0]        wstrb_d;
    logic              wvalid_d;

    logic              accept;
    logic              tmo_hit;

    function automatic logic is_illegal(input logic we, input logic [1:0] addr_lo,
                                        input logic [2:0] f3);
        logic bad;
        bad = 1'b0;
        case (f3)
            3'd0, 3'd4: bad = we && (f3 == 3'd4);
            3'd1:       bad = addr_lo[0];
            3'd5:       bad = we || addr_lo[0];
            3'd2:       bad = (addr_lo != 2'b00);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [7:0] strobe_of(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            default: return 8'h0f;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_ext(input logic [2:0] f3,
                                                   input logic [DATA_W-1:0] data);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [DATA_W-1:0]  res;
        b = data[7:0];
        h = data[15:0];
        case (f3)
            3'd0:    res = DATA_W'(b);
            3'd1:    res = DATA_W'(h);
            3'd4:    res = DATA_W'(data[7:0]);
            3'd5:    res = DATA_W'(data[15:0]);
            default: res = data;
        endcase
        return res;
    endfunction

    assign req_ready_o = (state == IDLE);
    assign accept      = (state == IDLE) && req_valid;
    assign tmo_hit     = (tmo_cnt == TMO_W'(TMO_MAX));

    // Width code travels with the transaction so the late rvalid can pick the extension
    always_ff @(posedge clk) begin
        if (accept) begin
            funct3_p0 <= req_funct3;
        end
    end

    always_comb begin
        state_d     = state;
        tmo_cnt_d   = tmo_cnt;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_o;
        araddr_d    = lsu_araddr_o;
        arvalid_d   = lsu_arvalid_o;
        rstrb_d     = lsu_rstrb_o;
        awaddr_d    = lsu_awaddr_o;
        awvalid_d   = lsu_awvalid_o;
        wdata_d     = lsu_wdata_o;
        wstrb_d     = lsu_wstrb_o;
        wvalid_d    = lsu_wvalid_o;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    tmo_cnt_d = '0;
                    if (is_illegal(req_we, req_addr[1:0], req_funct3)) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (req_we) begin
                        state_d   = STORE;
                        awaddr_d  = req_addr;
                        wdata_d   = req_wdata;
                        wstrb_d   = strobe_of(req_funct3);
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = LOAD;
                        araddr_d  = req_addr;
                        rstrb_d   = strobe_of(req_funct3);
                        arvalid_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                // A response on the timeout edge still wins
                if (lsu_rvalid) begin
                    state_d     = RESP;
                    arvalid_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_ext(funct3_p0, lsu_rdata);
                end else if (tmo_hit) begin
                    state_d     = RESP;
                    arvalid_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt + 1'b1;
                end
            end
            STORE: begin
                if (lsu_wready || tmo_hit) begin
                    state_d     = RESP;
                    awvalid_d   = 1'b0;
                    wvalid_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !lsu_wready;
                    rsp_rdata_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_err_o     <= 1'b0;
            rsp_rdata_o   <= '0;
            lsu_araddr_o  <= '0;
            lsu_arvalid_o <= 1'b0;
            lsu_rstrb_o   <= '0;
            lsu_awaddr_o  <= '0;
            lsu_awvalid_o <= 1'b0;
            lsu_wdata_o   <= '0;
            lsu_wstrb_o   <= '0;
            lsu_wvalid_o  <= 1'b0;
        end else begin
            state         <= state_d;
            tmo_cnt       <= tmo_cnt_d;
            rsp_valid_o   <= rsp_valid_d;
            rsp_err_o     <= rsp_err_d;
            rsp_rdata_o   <= rsp_rdata_d;
            lsu_araddr_o  <= araddr_d;
            lsu_arvalid_o <= arvalid_d;
            lsu_rstrb_o   <= rstrb_d;
            lsu_awaddr_o  <= awaddr_d;
            lsu_awvalid_o <= awvalid_d;
            lsu_wdata_o   <= wdata_d;
            lsu_wstrb_o   <= wstrb_d;
            lsu_wvalid_o  <= wvalid_d;
        end
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: directed and random requests, expected responses queued into a
// scoreboard that a negedge monitor drains whenever rsp_valid_o pulses.
module tb_lsu_bus_ctrl;

    localparam int TMO_MAX = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready_o;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] lsu_araddr_o;
    logic        lsu_arvalid_o;
    logic [7:0]  lsu_rstrb_o;
    logic [31:0] lsu_rdata;
    logic        lsu_rvalid;
    logic [31:0] lsu_awaddr_o;
    logic        lsu_awvalid_o;
    logic [31:0] lsu_wdata_o;
    logic [7:0]  lsu_wstrb_o;
    logic        lsu_wvalid_o;
    logic        lsu_wready;

    lsu_bus_ctrl #(.ADDR_W(32), .DATA_W(32), .TMO_W(8), .TMO_MAX(TMO_MAX)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready_o(req_ready_o), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .lsu_araddr_o(lsu_araddr_o), .lsu_arvalid_o(lsu_arvalid_o), .lsu_rstrb_o(lsu_rstrb_o),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .lsu_awaddr_o(lsu_awaddr_o), .lsu_awvalid_o(lsu_awvalid_o),
        .lsu_wdata_o(lsu_wdata_o), .lsu_wstrb_o(lsu_wstrb_o), .lsu_wvalid_o(lsu_wvalid_o),
        .lsu_wready(lsu_wready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_rdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference rules written directly from the width-code table
    function automatic logic model_illegal(input logic we, input logic [31:0] addr,
                                           input logic [2:0] f3);
        if (f3 == 3'd3 || f3 >= 3'd6) return 1'b1;
        if (we && f3 > 3'd2) return 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) return 1'b1;
        if (f3 == 3'd2 && (addr % 4 != 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] v;
        case (f3)
            3'd0: begin v = d & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
            3'd1: begin v = d & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
            3'd4: v = d & 32'hFF;
            3'd5: v = d & 32'hFFFF;
            default: v = d;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] model_strb(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 8'h01;
        if (f3 == 3'd1 || f3 == 3'd5) return 8'h03;
        return 8'h0f;
    endfunction

    always @(negedge clk) begin
        if (rsp_valid_o) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", {31'b0, rsp_valid_o}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rsp_rdata", rsp_rdata_o, e.rdata);
                chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, e.err});
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            if (req_ready_o) break;
            @(negedge clk);
        end
        chk("ready_timeout", {31'b0, req_ready_o}, 32'd1);
    endtask

    task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input int delay, input logic [31:0] bus_data,
                           input bit no_resp);
        exp_t        e;
        logic        ill;
        logic [7:0]  strb;
        int          cyc;
        int          exp_cyc;
        logic        bus_v;
        ill  = model_illegal(we, addr, f3);
        strb = model_strb(f3);
        e.err   = ill || no_resp;
        e.rdata = (ill || we || no_resp) ? 32'h0 : model_ext(f3, bus_data);

        wait_ready();
        chk("rdata_hold", rsp_rdata_o, last_rdata);
        sb_q.push_back(e);
        last_rdata = e.rdata;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = $urandom; req_addr = $urandom; req_wdata = $urandom;
        req_funct3 = 3'($urandom);

        if (ill) begin
            chk("err_no_arvalid", {31'b0, lsu_arvalid_o}, 32'd0);
            chk("err_no_awvalid", {31'b0, lsu_awvalid_o}, 32'd0);
            chk("err_latency", {31'b0, rsp_valid_o}, 32'd1);
        end else begin
            cyc = 0;
            for (int i = 0; i < 400; i++) begin
                bus_v = we ? lsu_awvalid_o : lsu_arvalid_o;
                if (!bus_v) break;
                cyc++;
                if (we) begin
                    chk("wvalid", {31'b0, lsu_wvalid_o}, 32'd1);
                    chk("awaddr", lsu_awaddr_o, addr);
                    chk("wdata", lsu_wdata_o, wdata);
                    chk("wstrb", {24'b0, lsu_wstrb_o}, {24'b0, strb});
                    chk("no_arvalid", {31'b0, lsu_arvalid_o}, 32'd0);
                end else begin
                    chk("araddr", lsu_araddr_o, addr);
                    chk("rstrb", {24'b0, lsu_rstrb_o}, {24'b0, strb});
                    chk("no_awvalid", {31'b0, lsu_awvalid_o}, 32'd0);
                end
                if (!no_resp && cyc == delay + 1) begin
                    if (we) lsu_wready = 1'b1;
                    else begin lsu_rvalid = 1'b1; lsu_rdata = bus_data; end
                end else begin
                    lsu_rdata = $urandom;
                end
                @(posedge clk);
                @(negedge clk);
                lsu_rvalid = 1'b0; lsu_wready = 1'b0;
            end
            exp_cyc = no_resp ? TMO_MAX + 1 : delay + 1;
            chk("bus_valid_cycles", cyc, exp_cyc);
            chk("wvalid_drop", {31'b0, lsu_wvalid_o}, 32'd0);
            chk("rsp_latency", {31'b0, rsp_valid_o}, 32'd1);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_funct3 = '0; lsu_rdata = '0; lsu_rvalid = 1'b0; lsu_wready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err_o}, 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'd0);
        chk("rst_valids", {29'b0, lsu_arvalid_o, lsu_awvalid_o, lsu_wvalid_o}, 32'd0);
        chk("rst_addrs", lsu_araddr_o | lsu_awaddr_o | lsu_wdata_o, 32'd0);
        chk("rst_strbs", {16'b0, lsu_rstrb_o, lsu_wstrb_o}, 32'd0);
        rst = 1'b0;
        chk("rst_ready", {31'b0, req_ready_o}, 32'd1);

        // Directed cases
        run_req(1'b0, 32'h8000_0003, 32'h0, 3'd0, 2, 32'h0000_0080, 1'b0);
        run_req(1'b0, 32'h8000_0002, 32'h0, 3'd5, 1, 32'h1234_F00D, 1'b0);
        run_req(1'b0, 32'h8000_0002, 32'h0, 3'd1, 0, 32'h1234_F00D, 1'b0);
        run_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 3'd2, 5, 32'h0, 1'b0);
        run_req(1'b0, 32'h8000_0002, 32'h0, 3'd2, 0, 32'h0, 1'b0);
        run_req(1'b1, 32'h8000_0001, 32'h55, 3'd1, 0, 32'h0, 1'b0);
        run_req(1'b1, 32'h8000_0000, 32'h55, 3'd4, 0, 32'h0, 1'b0);
        run_req(1'b0, 32'h8000_0000, 32'h0, 3'd3, 0, 32'h0, 1'b0);
        run_req(1'b1, 32'h8000_0003, 32'h0000_00A5, 3'd0, 0, 32'h0, 1'b0);
        run_req(1'b0, 32'h8000_0004, 32'h0, 3'd2, 0, 32'hCAFE_0000, 1'b1);
        run_req(1'b0, 32'h8000_0008, 32'h0, 3'd2, 0, 32'h1111_2222, 1'b0);
        run_req(1'b0, 32'h8000_000C, 32'h0, 3'd2, TMO_MAX, 32'h7777_8888, 1'b0);
        run_req(1'b1, 32'h8000_0020, 32'h0BAD_F00D, 3'd2, 0, 32'h0, 1'b1);

        // Reset two cycles into a load, then a stale rvalid
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0040; req_funct3 = 3'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_rdata = 32'h0;
        chk("post_rst_ready", {31'b0, req_ready_o}, 32'd1);
        lsu_rvalid = 1'b1; lsu_rdata = 32'h9999_9999;
        @(posedge clk);
        @(negedge clk);
        lsu_rvalid = 1'b0;
        chk("late_rvalid_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
        chk("late_rvalid_ready", {31'b0, req_ready_o}, 32'd1);
        chk("late_rvalid_valids", {29'b0, lsu_arvalid_o, lsu_awvalid_o, lsu_wvalid_o}, 32'd0);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
            run_req(1'($urandom), a, $urandom, 3'($urandom), int'($urandom_range(0, 4)),
                    $urandom, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
